// File: rtl/mem_slot_arbiter_if.sv
// Purpose: bundles the video, CPU and RAM-side signals of mem_slot_arbiter.
// Latency: none (wires only).
// Backpressure: requests are levels held until the matching one-cycle ack.
// Ports (slave = arbiter side):
//   video: vreq/va in, vack/vq out
//   cpu:   creq/cwr/ca/cd in, cack/cq out (plus cwait out when MEM_SLOT_ARBITER_WAIT_EN)
//   ram:   ram_q in, ram_a/ram_d/ram_we out
interface mem_slot_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          vreq;
  logic [AW-1:0] va;
  logic          vack;
  logic [DW-1:0] vq;
  logic          creq;
  logic          cwr;
  logic [AW-1:0] ca;
  logic [DW-1:0] cd;
  logic          cack;
  logic [DW-1:0] cq;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;
`ifdef MEM_SLOT_ARBITER_WAIT_EN
  logic          cwait;

  modport slave (
    input  vreq, va, creq, cwr, ca, cd, ram_q,
    output vack, vq, cack, cq, ram_a, ram_d, ram_we, cwait
  );
  modport master (
    output vreq, va, creq, cwr, ca, cd, ram_q,
    input  vack, vq, cack, cq, ram_a, ram_d, ram_we, cwait
  );
`else
  modport slave (
    input  vreq, va, creq, cwr, ca, cd, ram_q,
    output vack, vq, cack, cq, ram_a, ram_d, ram_we
  );
  modport master (
    output vreq, va, creq, cwr, ca, cd, ram_q,
    input  vack, vq, cack, cq, ram_a, ram_d, ram_we
  );
`endif
endinterface

// File: rtl/mem_slot_arbiter.sv
// Purpose: shares one synchronous RAM port between video fetch and the Z80, slot-timed.
// Latency: ack pulses LAT+1 clock edges after the grant edge (grant only on a slot strobe).
// Backpressure: req levels wait for a strobe; owner of the slot wins, idle slots go to the other side.
// Ports: clock, reset (sync, active high), slot (one-cycle strobe), bus (mem_slot_arbiter_if.slave).
// Optional: define MEM_SLOT_ARBITER_WAIT_EN to add bus.cwait (Z80 WAIT stretch while CPU waits for a grant).
module mem_slot_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int LAT = 2
) (
  input logic               clock,
  input logic               reset,
  input logic               slot,
  mem_slot_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  state_t        state_q, state_d;
  logic          phase_q, phase_d;     // 0 = video-owned slot, 1 = CPU-owned slot
  logic [2:0]    cnt_q, cnt_d;
  logic          issue_q, issue_d;     // first ACCESS cycle: address is on its way into the RAM
  logic          gnt_cpu_q, gnt_cpu_d;
  logic          cwr_q, cwr_d;
  logic          vack_q, vack_d;
  logic          cack_q, cack_d;
  logic [DW-1:0] vq_q, vq_d;
  logic [DW-1:0] cq_q, cq_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [DW-1:0] ram_d_q, ram_d_d;
  logic          ram_we_q, ram_we_d;

  logic grant;
  logic pick_cpu;
  logic access_end;

  // The owner is the phase before this strobe's toggle; the other side only
  // gets the slot when the owner is not asking for it.
  assign pick_cpu   = phase_q ? bus.creq : (bus.creq & ~bus.vreq);
  assign grant      = (state_q == IDLE) & slot & (bus.vreq | bus.creq);
  // The issue cycle does not count down, so the ack lands LAT+1 edges after
  // the grant: one edge to register the address, LAT edges of RAM latency.
  assign access_end = (state_q == ACCESS) & ~issue_q & (cnt_q == 3'd0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      cnt_q     <= 3'd0;
      issue_q   <= 1'b0;
      gnt_cpu_q <= 1'b0;
      cwr_q     <= 1'b0;
      vack_q    <= 1'b0;
      cack_q    <= 1'b0;
      vq_q      <= '0;
      cq_q      <= '0;
      ram_a_q   <= '0;
      ram_d_q   <= '0;
      ram_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      issue_q   <= issue_d;
      gnt_cpu_q <= gnt_cpu_d;
      cwr_q     <= cwr_d;
      vack_q    <= vack_d;
      cack_q    <= cack_d;
      vq_q      <= vq_d;
      cq_q      <= cq_d;
      ram_a_q   <= ram_a_d;
      ram_d_q   <= ram_d_d;
      ram_we_q  <= ram_we_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  if (access_end) state_d = DONE;
      DONE:    state_d = IDLE;  // a strobe landing here is lost
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    phase_d   = phase_q ^ slot;  // toggles on every strobe regardless of state
    cnt_d     = cnt_q;
    issue_d   = 1'b0;
    gnt_cpu_d = gnt_cpu_q;
    cwr_d     = cwr_q;
    vack_d    = 1'b0;
    cack_d    = 1'b0;
    vq_d      = vq_q;
    cq_d      = cq_q;
    ram_a_d   = ram_a_q;
    ram_d_d   = ram_d_q;
    ram_we_d  = 1'b0;            // write strobe lasts only the cycle after the grant edge

    if (grant) begin
      gnt_cpu_d = pick_cpu;
      cnt_d     = CNT_INIT;
      issue_d   = 1'b1;
      if (pick_cpu) begin
        ram_a_d  = bus.ca;
        ram_d_d  = bus.cd;
        cwr_d    = bus.cwr;
        ram_we_d = bus.cwr;
      end else begin
        ram_a_d  = bus.va;
        cwr_d    = 1'b0;
      end
    end else if (state_q == ACCESS && !issue_q) begin
      if (cnt_q != 3'd0) begin
        cnt_d = cnt_q - 3'd1;
      end else if (gnt_cpu_q) begin
        cack_d = 1'b1;
        if (!cwr_q) cq_d = bus.ram_q;
      end else begin
        vack_d = 1'b1;
        vq_d   = bus.ram_q;
      end
    end
  end

  assign bus.vack   = vack_q;
  assign bus.vq     = vq_q;
  assign bus.cack   = cack_q;
  assign bus.cq     = cq_q;
  assign bus.ram_a  = ram_a_q;
  assign bus.ram_d  = ram_d_q;
  assign bus.ram_we = ram_we_q;

`ifdef MEM_SLOT_ARBITER_WAIT_EN
  // CPU access in flight from the grant edge through the cack (DONE) cycle.
  logic cpu_busy;
  assign cpu_busy  = gnt_cpu_q & (state_q != IDLE);
  assign bus.cwait = bus.creq & ~cpu_busy & ~reset;
`endif

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Purpose: directed bench for mem_slot_arbiter with a LAT=2 RAM model.
// Latency: expects acks 3 edges after the grant strobe.
// Backpressure: requests held as levels until ack, strobes every 8 clocks.
module tb_mem_slot_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic slot  = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mem_slot_arbiter_if #(.AW(16), .DW(8)) bus ();

  mem_slot_arbiter #(.AW(16), .DW(8), .LAT(2)) dut (
    .clock (clock),
    .reset (reset),
    .slot  (slot),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Two-stage synchronous RAM: data for the address registered at edge N is
  // visible after edge N+2 and captured by the arbiter at edge N+3.
  function automatic logic [7:0] ram_val(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'hE5;
  endfunction

  logic [7:0] q1 = 8'h00;
  logic [7:0] q2 = 8'h00;
  always @(posedge clock) begin
    q1 <= ram_val(bus.ram_a);
    q2 <= q1;
  end
  assign bus.ram_q = q2;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_slot();
    slot = 1'b1;
    tick();
    slot = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.vreq = 1'b0; bus.va = 16'h0000;
    bus.creq = 1'b0; bus.cwr = 1'b0; bus.ca = 16'h0000; bus.cd = 8'h00;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    slot = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Ticks until the selected ack appears (bounded); n = 0 means it never came.
  task automatic wait_ack(input bit cpu, output int n, output int we_cnt, output int other);
    n = 0; we_cnt = 0; other = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.ram_we) we_cnt++;
      if (cpu ? bus.vack : bus.cack) other++;
      if (cpu ? bus.cack : bus.vack) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int acks;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    tests_run++;
    if (bus.vack !== 1'b0 || bus.cack !== 1'b0 || bus.ram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: vack=%b cack=%b ram_we=%b want 0", bus.vack, bus.cack, bus.ram_we);
    end
    tests_run++;
    if (bus.vq !== 8'h00 || bus.cq !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: vq=%h cq=%h want 00", bus.vq, bus.cq);
    end
    tests_run++;
    if (bus.ram_a !== 16'h0000 || bus.ram_d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ram: ram_a=%h ram_d=%h want 0", bus.ram_a, bus.ram_d);
    end
    reset = 1'b0;
    // A strobe with nobody requesting grants nothing.
    pulse_slot();
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.vack || bus.cack) acks++;
    end
    tests_run++;
    if (acks !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_req_ack: acks=%0d want 0", acks);
    end
  endtask

  task automatic test_video_read();
    int n, we, other;
    apply_reset();
    bus.vreq = 1'b1; bus.va = 16'h4000;
    pulse_slot();
    tests_run++;
    if (bus.ram_a !== 16'h4000 || bus.ram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL video_grant: ram_a=%h ram_we=%b want 4000/0", bus.ram_a, bus.ram_we);
    end
    wait_ack(1'b0, n, we, other);
    tests_run++;
    if (n !== 3) begin
      tests_failed++;
      $display("FAIL video_latency: edges=%0d want 3", n);
    end
    tests_run++;
    if (bus.vq !== 8'hA5) begin
      tests_failed++;
      $display("FAIL video_data: vq=%h want a5", bus.vq);
    end
    bus.vreq = 1'b0;
    tick();
    tests_run++;
    if (bus.vack !== 1'b0 || bus.vq !== 8'hA5) begin
      tests_failed++;
      $display("FAIL video_ack_pulse: vack=%b vq=%h want 0/a5", bus.vack, bus.vq);
    end
  endtask

  task automatic test_contention();
    int n, we, other;
    apply_reset();
    bus.vreq = 1'b1; bus.va = 16'h4000;
    bus.creq = 1'b1; bus.cwr = 1'b0; bus.ca = 16'h1234;
    pulse_slot();
    tests_run++;
    if (bus.ram_a !== 16'h4000) begin
      tests_failed++;
      $display("FAIL contend_owner_video: ram_a=%h want 4000", bus.ram_a);
    end
    wait_ack(1'b0, n, we, other);
    tests_run++;
    if (n !== 3 || other !== 0 || bus.vq !== 8'hA5) begin
      tests_failed++;
      $display("FAIL contend_video_ack: edges=%0d cacks=%0d vq=%h want 3/0/a5", n, other, bus.vq);
    end
    bus.vreq = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (bus.ram_a !== 16'h4000 || bus.cack !== 1'b0) begin
      tests_failed++;
      $display("FAIL contend_cpu_waits: ram_a=%h cack=%b want 4000/0", bus.ram_a, bus.cack);
    end
    pulse_slot();
    tests_run++;
    if (bus.ram_a !== 16'h1234) begin
      tests_failed++;
      $display("FAIL contend_cpu_grant: ram_a=%h want 1234", bus.ram_a);
    end
    wait_ack(1'b1, n, we, other);
    tests_run++;
    if (n !== 3 || bus.cq !== 8'hC3) begin
      tests_failed++;
      $display("FAIL contend_cpu_ack: edges=%0d cq=%h want 3/c3", n, bus.cq);
    end
    bus.creq = 1'b0;
    tick();
  endtask

  task automatic test_cpu_idle_slot();
    int n, we, other;
    apply_reset();
    bus.creq = 1'b1; bus.cwr = 1'b0; bus.ca = 16'h2A55;
    pulse_slot();
    tests_run++;
    if (bus.ram_a !== 16'h2A55 || bus.ram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_slot_grant: ram_a=%h ram_we=%b want 2a55/0", bus.ram_a, bus.ram_we);
    end
    wait_ack(1'b1, n, we, other);
    tests_run++;
    if (n !== 3 || we !== 0) begin
      tests_failed++;
      $display("FAIL idle_slot_ack: edges=%0d we_cycles=%0d want 3/0", n, we);
    end
    tests_run++;
    if (bus.cq !== 8'h9A || bus.vq !== 8'h00) begin
      tests_failed++;
      $display("FAIL idle_slot_data: cq=%h vq=%h want 9a/00", bus.cq, bus.vq);
    end
    bus.creq = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write();
    int n, we, other;
    apply_reset();
    bus.creq = 1'b1; bus.cwr = 1'b0; bus.ca = 16'h2A55;
    pulse_slot();
    wait_ack(1'b1, n, we, other);
    bus.creq = 1'b1; bus.cwr = 1'b1; bus.ca = 16'h8000; bus.cd = 8'h3C;
    for (int i = 0; i < 4; i++) tick();
    pulse_slot();
    tests_run++;
    if (bus.ram_we !== 1'b1 || bus.ram_a !== 16'h8000 || bus.ram_d !== 8'h3C) begin
      tests_failed++;
      $display("FAIL write_strobe: ram_we=%b ram_a=%h ram_d=%h want 1/8000/3c", bus.ram_we, bus.ram_a, bus.ram_d);
    end
    wait_ack(1'b1, n, we, other);
    tests_run++;
    if (n !== 3 || we !== 0) begin
      tests_failed++;
      $display("FAIL write_ack: edges=%0d extra_we_cycles=%0d want 3/0", n, we);
    end
    tests_run++;
    if (bus.cq !== 8'h9A) begin
      tests_failed++;
      $display("FAIL write_cq_hold: cq=%h want 9a", bus.cq);
    end
    bus.creq = 1'b0; bus.cwr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int n, we, other, acks;
    apply_reset();
    bus.vreq = 1'b1; bus.va = 16'h4000;
    pulse_slot();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.vreq = 1'b0;
    tests_run++;
    if (bus.ram_a !== 16'h0000 || bus.vack !== 1'b0 || bus.vq !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_outputs: ram_a=%h vack=%b vq=%h want 0", bus.ram_a, bus.vack, bus.vq);
    end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.vack || bus.cack) acks++;
    end
    tests_run++;
    if (acks !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_ack: acks=%0d want 0", acks);
    end
    bus.vreq = 1'b1; bus.va = 16'h4001;
    bus.creq = 1'b1; bus.cwr = 1'b0; bus.ca = 16'h1234;
    pulse_slot();
    tests_run++;
    if (bus.ram_a !== 16'h4001) begin
      tests_failed++;
      $display("FAIL midreset_phase0: ram_a=%h want 4001", bus.ram_a);
    end
    wait_ack(1'b0, n, we, other);
    tests_run++;
    if (n !== 3 || bus.vq !== 8'hA4) begin
      tests_failed++;
      $display("FAIL midreset_video_ack: edges=%0d vq=%h want 3/a4", n, bus.vq);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_slot_lost_in_done();
    int n, we, other;
    apply_reset();
    bus.vreq = 1'b1; bus.va = 16'h4000;
    pulse_slot();
    wait_ack(1'b0, n, we, other);
    bus.vreq = 1'b0;
    bus.creq = 1'b1; bus.cwr = 1'b0; bus.ca = 16'h1234;
    // This strobe coincides with DONE: phase moves on but nothing is granted.
    pulse_slot();
    for (int i = 0; i < 7; i++) tick();
    tests_run++;
    if (bus.ram_a !== 16'h4000 || bus.cack !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_slot_lost: ram_a=%h cack=%b want 4000/0", bus.ram_a, bus.cack);
    end
    pulse_slot();
    tests_run++;
    if (bus.ram_a !== 16'h1234) begin
      tests_failed++;
      $display("FAIL done_next_grant: ram_a=%h want 1234", bus.ram_a);
    end
    wait_ack(1'b1, n, we, other);
    tests_run++;
    if (n !== 3 || bus.cq !== 8'hC3) begin
      tests_failed++;
      $display("FAIL done_cpu_ack: edges=%0d cq=%h want 3/c3", n, bus.cq);
    end
    bus.creq = 1'b0;
    tick();
  endtask

`ifdef MEM_SLOT_ARBITER_WAIT_EN
  task automatic test_cwait();
    int n, we, other;
    apply_reset();
    tests_run++;
    if (bus.cwait !== 1'b0) begin
      tests_failed++;
      $display("FAIL cwait_idle: cwait=%b want 0", bus.cwait);
    end
    tick();
    tick();
    bus.creq = 1'b1; bus.cwr = 1'b0; bus.ca = 16'h1234;
    #1;
    tests_run++;
    if (bus.cwait !== 1'b1) begin
      tests_failed++;
      $display("FAIL cwait_rise: cwait=%b want 1", bus.cwait);
    end
    tick();
    tests_run++;
    if (bus.cwait !== 1'b1) begin
      tests_failed++;
      $display("FAIL cwait_hold: cwait=%b want 1", bus.cwait);
    end
    pulse_slot();
    tests_run++;
    if (bus.cwait !== 1'b0) begin
      tests_failed++;
      $display("FAIL cwait_grant: cwait=%b want 0", bus.cwait);
    end
    wait_ack(1'b1, n, we, other);
    tests_run++;
    if (n !== 3 || bus.cwait !== 1'b0) begin
      tests_failed++;
      $display("FAIL cwait_at_ack: edges=%0d cwait=%b want 3/0", n, bus.cwait);
    end
    bus.creq = 1'b0;
    tick();
    tests_run++;
    if (bus.cwait !== 1'b0) begin
      tests_failed++;
      $display("FAIL cwait_after: cwait=%b want 0", bus.cwait);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_video_read();
    test_contention();
    test_cpu_idle_slot();
    test_cpu_write();
    test_reset_mid_access();
    test_slot_lost_in_done();
`ifdef MEM_SLOT_ARBITER_WAIT_EN
    test_cwait();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

endmodule
